// File: rtl/pump3_sequencer.sv
// Three-valve peristaltic pump sequencer: opens the selected inlet, drives N six-phase
// strokes on the pump air lines, then seals. Air line 1 = valve closed.
module pump3_sequencer #(
    parameter int PHASE_W  = 16,
    parameter int STROKE_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic                dir,
    input  logic [1:0]          src_sel,
    input  logic [PHASE_W-1:0]  phase_len,
    input  logic [STROKE_W-1:0] strokes,
    output logic                pump1,
    output logic                pump2,
    output logic                pump3,
    output logic                sa,
    output logic                sb,
    output logic                sc,
    output logic                busy,
    output logic                done,
    output logic                aborted,
    output logic [STROKE_W-1:0] stroke_cnt
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_OPEN  = 2'd1;
    localparam logic [1:0] S_PUMP  = 2'd2;
    localparam logic [1:0] S_CLOSE = 2'd3;

    logic [1:0]          state_q, state_n;
    logic [2:0]          phase_q, phase_n;
    logic [PHASE_W-1:0]  cnt_q, cnt_n;
    logic [PHASE_W-1:0]  len_q, len_n;
    logic [STROKE_W-1:0] strokes_q, strokes_n;
    logic [STROKE_W-1:0] stroke_n;
    logic [1:0]          src_q, src_n;
    logic                dir_q, dir_n;
    logic                done_n, aborted_n;
    logic [2:0]          pump_n, mux_n;

    // Forward pattern {p1,p2,p3}; reverse swaps p1 and p3.
    function automatic logic [2:0] pump_pat(input logic [2:0] ph, input logic rev);
        logic [2:0] p;
        case (ph)
            3'd0:    p = 3'b011;
            3'd1:    p = 3'b001;
            3'd2:    p = 3'b101;
            3'd3:    p = 3'b100;
            3'd4:    p = 3'b110;
            default: p = 3'b111;
        endcase
        return rev ? {p[0], p[1], p[2]} : p;
    endfunction

    always_comb begin
        state_n   = state_q;
        phase_n   = phase_q;
        cnt_n     = cnt_q;
        len_n     = len_q;
        strokes_n = strokes_q;
        stroke_n  = stroke_cnt;
        src_n     = src_q;
        dir_n     = dir_q;
        done_n    = 1'b0;
        aborted_n = 1'b0;
        if (state_q == S_IDLE) begin
            if (start) begin
                len_n     = (phase_len == '0) ? PHASE_W'(1) : phase_len;
                strokes_n = strokes;
                src_n     = src_sel;
                dir_n     = dir;
                stroke_n  = '0;
                cnt_n     = '0;
                phase_n   = '0;
                if (strokes != '0) state_n = S_OPEN;
                else               done_n  = 1'b1;
            end
        end else if (abort) begin
            state_n   = S_IDLE;
            cnt_n     = '0;
            phase_n   = '0;
            aborted_n = 1'b1;
        end else if (cnt_q == len_q - PHASE_W'(1)) begin
            cnt_n = '0;
            case (state_q)
                S_OPEN: begin
                    state_n = S_PUMP;
                    phase_n = '0;
                end
                S_PUMP: begin
                    if (phase_q == 3'd5) begin
                        stroke_n = stroke_cnt + STROKE_W'(1);
                        phase_n  = '0;
                        if (stroke_n == strokes_q) state_n = S_CLOSE;
                    end else begin
                        phase_n = phase_q + 3'd1;
                    end
                end
                default: begin
                    state_n = S_IDLE;
                    done_n  = 1'b1;
                end
            endcase
        end else begin
            cnt_n = cnt_q + PHASE_W'(1);
        end

        // Outputs are registered from next-state values so they line up with the state.
        pump_n = (state_n == S_PUMP) ? pump_pat(phase_n, dir_n) : 3'b111;
        mux_n  = 3'b111;
        if ((state_n == S_OPEN || state_n == S_PUMP) && src_n != 2'd3)
            mux_n[2'd2 - src_n] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            phase_q    <= '0;
            cnt_q      <= '0;
            len_q      <= PHASE_W'(1);
            strokes_q  <= '0;
            src_q      <= 2'd3;
            dir_q      <= 1'b0;
            stroke_cnt <= '0;
            {pump1, pump2, pump3} <= 3'b111;
            {sa, sb, sc}          <= 3'b111;
            busy       <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
        end else begin
            state_q    <= state_n;
            phase_q    <= phase_n;
            cnt_q      <= cnt_n;
            len_q      <= len_n;
            strokes_q  <= strokes_n;
            src_q      <= src_n;
            dir_q      <= dir_n;
            stroke_cnt <= stroke_n;
            {pump1, pump2, pump3} <= pump_n;
            {sa, sb, sc}          <= mux_n;
            busy       <= (state_n != S_IDLE);
            done       <= done_n;
            aborted    <= aborted_n;
        end
    end
endmodule

// File: tb/tb_pump3_sequencer.sv
// Bench for pump3_sequencer: each job's expected output trace is built cycle by cycle
// from the pump timing rules, then compared against the DUT every cycle.
module tb_pump3_sequencer;
    logic        clk = 1'b0;
    logic        rst, start, abort, dir;
    logic [1:0]  src_sel;
    logic [15:0] phase_len;
    logic [7:0]  strokes;
    logic        pump1, pump2, pump3, sa, sb, sc, busy, done, aborted;
    logic [7:0]  stroke_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    logic [16:0] exp_q[$];
    logic [2:0]  fwd[6] = '{3'b011, 3'b001, 3'b101, 3'b100, 3'b110, 3'b111};

    pump3_sequencer #(.PHASE_W(16), .STROKE_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .dir(dir),
        .src_sel(src_sel), .phase_len(phase_len), .strokes(strokes),
        .pump1(pump1), .pump2(pump2), .pump3(pump3), .sa(sa), .sb(sb), .sc(sc),
        .busy(busy), .done(done), .aborted(aborted), .stroke_cnt(stroke_cnt)
    );

    always #5 clk = ~clk;

    // {p1,p2,p3, sa,sb,sc, busy, done, aborted, stroke_cnt}
    function automatic logic [16:0] pack(input logic [2:0] p, input logic [2:0] m,
                                         input logic b, input logic d, input logic a,
                                         input logic [7:0] s);
        return {p, m, b, d, a, s};
    endfunction

    function automatic logic [16:0] obs();
        return {pump1, pump2, pump3, sa, sb, sc, busy, done, aborted, stroke_cnt};
    endfunction

    task automatic chk(input string tag, input logic [16:0] got, input logic [16:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble();
        dir       = 1'($urandom);
        src_sel   = 2'($urandom);
        phase_len = 16'($urandom_range(0, 5));
        strokes   = 8'($urandom_range(0, 5));
    endtask

    // Expected trace starting at the first cycle after the start edge.
    task automatic build(input logic [1:0] src, input logic d, input logic [15:0] len,
                         input logic [7:0] n);
        int le;
        logic [2:0] m, pat;
        le = (len == 0) ? 1 : int'(len);
        exp_q.delete();
        if (n == 0) begin
            exp_q.push_back(pack(3'b111, 3'b111, 1'b0, 1'b1, 1'b0, 8'd0));
            return;
        end
        m = 3'b111;
        if (src != 2'd3) m[2 - src] = 1'b0;
        for (int i = 0; i < le; i++) exp_q.push_back(pack(3'b111, m, 1'b1, 1'b0, 1'b0, 8'd0));
        for (int s = 0; s < int'(n); s++)
            for (int ph = 0; ph < 6; ph++) begin
                pat = fwd[ph];
                if (d) pat = {pat[0], pat[1], pat[2]};
                for (int i = 0; i < le; i++)
                    exp_q.push_back(pack(pat, m, 1'b1, 1'b0, 1'b0, 8'(s)));
            end
        for (int i = 0; i < le; i++) exp_q.push_back(pack(3'b111, 3'b111, 1'b1, 1'b0, 1'b0, n));
        exp_q.push_back(pack(3'b111, 3'b111, 1'b0, 1'b1, 1'b0, n));
    endtask

    // ab_at / rst_at / ms_at: trace index at which abort / reset / a stray start is driven (-1 = never).
    task automatic run_job(input string tag, input logic [1:0] src, input logic d,
                           input logic [15:0] len, input logic [7:0] n,
                           input int ab_at, input int rst_at, input int ms_at);
        logic [7:0] last;
        logic [16:0] cur;
        build(src, d, len, n);
        src_sel = src; dir = d; phase_len = len; strokes = n; start = 1'b1;
        tick();
        start = 1'b0;
        scramble();
        last = exp_q[exp_q.size() - 1][7:0];
        for (int k = 0; k < exp_q.size(); k++) begin
            cur = exp_q[k];
            chk(tag, obs(), cur);
            if (k == ab_at) begin
                abort = 1'b1;
                tick();
                abort = 1'b0;
                chk({tag, "_abort"}, obs(), pack(3'b111, 3'b111, 1'b0, 1'b0, 1'b1, cur[7:0]));
                last = cur[7:0];
                tick();
                break;
            end
            if (k == rst_at) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                chk({tag, "_rst"}, obs(), pack(3'b111, 3'b111, 1'b0, 1'b0, 1'b0, 8'd0));
                last = 8'd0;
                tick();
                break;
            end
            if (k == ms_at) begin
                scramble();
                strokes = 8'd1;
                start   = 1'b1;
            end
            tick();
            start = 1'b0;
        end
        chk({tag, "_idle"}, obs(), pack(3'b111, 3'b111, 1'b0, 1'b0, 1'b0, last));
    endtask

    initial begin
        int ln, nn, tot, ab, ms;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        dir = 1'b0; src_sel = 2'd0; phase_len = 16'd0; strokes = 8'd0;
        tick(); tick();
        chk("reset", obs(), pack(3'b111, 3'b111, 1'b0, 1'b0, 1'b0, 8'd0));
        rst = 1'b0;
        tick();
        chk("post_reset", obs(), pack(3'b111, 3'b111, 1'b0, 1'b0, 1'b0, 8'd0));

        run_job("fwd_b_L2_N1", 2'd1, 1'b0, 16'd2, 8'd1, -1, -1, -1);
        run_job("rev_none_L0_N2", 2'd3, 1'b1, 16'd0, 8'd2, -1, -1, -1);
        run_job("n_zero", 2'd0, 1'b0, 16'd3, 8'd0, -1, -1, -1);
        // Abort during stroke 2, first cycle of phase 3.
        run_job("abort_s2p3", 2'd2, 1'b0, 16'd4, 8'd3, 4 + (6 + 3) * 4, -1, -1);
        run_job("mid_start", 2'd0, 1'b1, 16'd3, 8'd2, -1, -1, 10);
        run_job("rst_pump", 2'd1, 1'b0, 16'd2, 8'd3, -1, 2 + 6 * 2 + 5, -1);
        run_job("after_rst", 2'd2, 1'b1, 16'd2, 8'd2, -1, -1, -1);
        run_job("abort_open", 2'd0, 1'b0, 16'd3, 8'd1, 0, -1, -1);
        run_job("abort_close", 2'd1, 1'b0, 16'd1, 8'd1, 7, -1, -1);
        run_job("full_strokes", 2'd2, 1'b0, 16'd1, 8'd255, -1, -1, -1);

        for (int j = 0; j < 40; j++) begin
            ln  = $urandom_range(0, 4);
            nn  = $urandom_range(0, 4);
            tot = ((ln == 0) ? 1 : ln) * (6 * nn + 2);
            ab  = (nn != 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, tot - 1)) : -1;
            ms  = (nn != 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, tot - 1)) : -1;
            run_job("rand", 2'($urandom), 1'($urandom), 16'(ln), 8'(nn), ab, -1, ms);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
